// File: rtl/sa_sep_alloc.sv
// Input-first separable switch allocator: per-input round-robin pick, then per-output round-robin pick.
// Optional packet locking (an output stays with one input until its tail flit) is enabled by SA_PKT_LOCK_EN.
module sa_sep_alloc #(
    parameter int unsigned P = 5,
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [P*P-1:0] req,
    input  logic [P-1:0]   tail,
    input  logic [P-1:0]   out_ready,
    output logic [P-1:0]   gnt_in,
    output logic [P*P-1:0] sel_out_for_in,
    output logic [P*P-1:0] sel_in_for_out
);

    logic [PW-1:0] ip_ptr [P];
    logic [PW-1:0] op_ptr [P];
    logic [PW-1:0] ip_nxt [P];
    logic [PW-1:0] op_nxt [P];

    logic [P*P-1:0] mreq;
    logic [P*P-1:0] s1;
    logic [P*P-1:0] sel_io;
    logic [P*P-1:0] sel_oi;

`ifdef SA_PKT_LOCK_EN
    logic [P-1:0]  lock_vld;
    logic [P-1:0]  lock_vld_nxt;
    logic [PW-1:0] lock_own [P];
    logic [PW-1:0] lock_own_nxt [P];
`else
    logic unused_tail;
    assign unused_tail = ^tail;
`endif

    // First set bit of v at or above ptr, wrapping P-1 -> 0; one-hot result.
    function automatic logic [P-1:0] rr_pick(input logic [P-1:0] v, input logic [PW-1:0] ptr);
        logic [P-1:0] g;
        logic         found;
        int unsigned  idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= P) idx = idx - P;
            if (!found && v[PW'(idx)]) begin
                g[PW'(idx)] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] enc(input logic [P-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < P; k++) begin
            if (v[k]) r = PW'(k);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
        return (x == PW'(P - 1)) ? '0 : x + PW'(1);
    endfunction

    // Ready/lock masking and stage-1 choice per input
    always_comb begin
        logic [P-1:0] row;
        logic [P-1:0] owned;
        mreq  = '0;
        s1    = '0;
        row   = '0;
        owned = '0;
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned o = 0; o < P; o++) begin
                mreq[i*P+o] = req[i*P+o] & out_ready[o];
`ifdef SA_PKT_LOCK_EN
                owned[o] = lock_vld[o] && (lock_own[o] == PW'(i));
                if (lock_vld[o] && !owned[o]) mreq[i*P+o] = 1'b0;
`endif
            end
            row = mreq[i*P +: P];
            if (|owned) s1[i*P +: P] = row & owned;
            else        s1[i*P +: P] = rr_pick(row, ip_ptr[i]);
        end
    end

    // Stage 2: one winner per output among inputs that chose it
    always_comb begin
        logic [P-1:0] col;
        logic [P-1:0] pk;
        sel_io = '0;
        sel_oi = '0;
        col    = '0;
        pk     = '0;
        for (int unsigned o = 0; o < P; o++) begin
            for (int unsigned i = 0; i < P; i++) col[i] = s1[i*P+o];
            pk = rr_pick(col, op_ptr[o]);
            for (int unsigned i = 0; i < P; i++) begin
                sel_oi[o*P+i] = pk[i] & rstn;
                sel_io[i*P+o] = pk[i] & rstn;
            end
        end
    end

    always_comb begin
        gnt_in = '0;
        for (int unsigned i = 0; i < P; i++) gnt_in[i] = |sel_io[i*P +: P];
    end

    assign sel_out_for_in = sel_io;
    assign sel_in_for_out = sel_oi;

    // iSLIP pointer update and lock tracking
    always_comb begin
        logic [PW-1:0] w;
        w  = '0;
        ip_nxt = ip_ptr;
        op_nxt = op_ptr;
`ifdef SA_PKT_LOCK_EN
        lock_vld_nxt = lock_vld;
        lock_own_nxt = lock_own;
`endif
        for (int unsigned o = 0; o < P; o++) begin
            if (|sel_oi[o*P +: P]) begin
                w = enc(sel_oi[o*P +: P]);
`ifdef SA_PKT_LOCK_EN
                if (tail[w]) begin
                    op_nxt[o]       = inc(w);
                    lock_vld_nxt[o] = 1'b0;
                end else begin
                    lock_vld_nxt[o] = 1'b1;
                    lock_own_nxt[o] = w;
                end
`else
                op_nxt[o] = inc(w);
`endif
            end
        end
        for (int unsigned i = 0; i < P; i++) begin
            if (gnt_in[i]) ip_nxt[i] = inc(enc(sel_io[i*P +: P]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < P; k++) begin
                ip_ptr[k] <= '0;
                op_ptr[k] <= '0;
`ifdef SA_PKT_LOCK_EN
                lock_own[k] <= '0;
`endif
            end
`ifdef SA_PKT_LOCK_EN
            lock_vld <= '0;
`endif
        end else begin
            for (int unsigned k = 0; k < P; k++) begin
                ip_ptr[k] <= ip_nxt[k];
                op_ptr[k] <= op_nxt[k];
`ifdef SA_PKT_LOCK_EN
                lock_own[k] <= lock_own_nxt[k];
`endif
            end
`ifdef SA_PKT_LOCK_EN
            lock_vld <= lock_vld_nxt;
`endif
        end
    end

endmodule
